// File: rtl/riscv_pkg.sv
// Shared RV32I core definitions: opcodes, ALU op classes and the ID->EX control bundle.
package riscv_pkg;

  localparam logic [6:0] OPC_R      = 7'b0110011;
  localparam logic [6:0] OPC_I_ALU  = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;

  typedef enum logic [1:0] {
    ALUOP_OTHER = 2'b00,
    ALUOP_MEM   = 2'b01,
    ALUOP_IALU  = 2'b10,
    ALUOP_R     = 2'b11
  } aluop_e;

  typedef struct packed {
    aluop_e alu_op;
    logic   alu_src;
    logic   reg_write;
    logic   mem_read;
    logic   mem_write;
    logic   mem_to_reg;
  } ctrl_t;

  localparam ctrl_t CTRL_NOP = '{alu_op: ALUOP_OTHER, default: 1'b0};

  // Stores read rs2 as write data even though operand B is the immediate.
  function automatic logic uses_rs2(input logic alu_src, input logic mem_write);
    return ~alu_src | mem_write;
  endfunction

  function automatic ctrl_t ctrl_from_opcode(input logic [6:0] opcode);
    ctrl_t c;
    c = CTRL_NOP;
    case (opcode)
      OPC_R:     begin c.alu_op = ALUOP_R;    c.reg_write = 1'b1; end
      OPC_I_ALU: begin c.alu_op = ALUOP_IALU; c.alu_src = 1'b1; c.reg_write = 1'b1; end
      OPC_LOAD:  begin
        c.alu_op     = ALUOP_MEM;
        c.alu_src    = 1'b1;
        c.reg_write  = 1'b1;
        c.mem_read   = 1'b1;
        c.mem_to_reg = 1'b1;
      end
      OPC_STORE: begin c.alu_op = ALUOP_MEM; c.alu_src = 1'b1; c.mem_write = 1'b1; end
      default:   c = CTRL_NOP;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/load_use_detect.sv
// Combinational load-use hazard check: a load in EX whose rd feeds a source read by ID.
module load_use_detect #(
  parameter int REG_AW = 5
) (
  input  logic              id_valid,
  input  logic [REG_AW-1:0] id_rs1,
  input  logic [REG_AW-1:0] id_rs2,
  input  logic              id_uses_rs2,
  input  logic              ex_valid,
  input  logic              ex_mem_read,
  input  logic [REG_AW-1:0] ex_rd,
  output logic              hazard
);

  logic ex_is_load;
  logic rs1_match;
  logic rs2_match;

  // x0 is hardwired, so a load targeting it never produces a dependency.
  assign ex_is_load = ex_valid & ex_mem_read & (ex_rd != '0);
  assign rs1_match  = (ex_rd == id_rs1);
  assign rs2_match  = id_uses_rs2 & (ex_rd == id_rs2);
  assign hazard     = id_valid & ex_is_load & (rs1_match | rs2_match);

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use bubble insertion, flush and downstream hold; 1-cycle latency.
// Optional hazard-bubble counter enabled by macro ID_EX_PERF_EN.
module id_ex_stage
  import riscv_pkg::*;
#(
  parameter int XLEN   = 32,
  parameter int REG_AW = 5
`ifdef ID_EX_PERF_EN
  ,
  parameter int PERF_W = 16
`endif
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              ID_valid_i,
  input  logic [1:0]        ID_ALUop_i,
  input  logic              ID_ALUsrc_i,
  input  logic              ID_RegWrite_i,
  input  logic              ID_MemRead_i,
  input  logic              ID_MemWrite_i,
  input  logic              ID_MemToReg_i,
  input  logic [XLEN-1:0]   ID_pc_i,
  input  logic [XLEN-1:0]   ID_rs1_data_i,
  input  logic [XLEN-1:0]   ID_rs2_data_i,
  input  logic [XLEN-1:0]   ID_imm_i,
  input  logic [REG_AW-1:0] ID_rs1_i,
  input  logic [REG_AW-1:0] ID_rs2_i,
  input  logic [REG_AW-1:0] ID_rd_i,
  input  logic [3:0]        ID_funct_i,
  input  logic              flush_i,
  input  logic              ex_stall_i,
  output logic              EX_valid_o,
  output logic [1:0]        EX_ALUop_o,
  output logic              EX_ALUsrc_o,
  output logic              EX_RegWrite_o,
  output logic              EX_MemRead_o,
  output logic              EX_MemWrite_o,
  output logic              EX_MemToReg_o,
  output logic [XLEN-1:0]   EX_pc_o,
  output logic [XLEN-1:0]   EX_rs1_data_o,
  output logic [XLEN-1:0]   EX_rs2_data_o,
  output logic [XLEN-1:0]   EX_imm_o,
  output logic [REG_AW-1:0] EX_rs1_o,
  output logic [REG_AW-1:0] EX_rs2_o,
  output logic [REG_AW-1:0] EX_rd_o,
  output logic [3:0]        EX_funct_o,
`ifdef ID_EX_PERF_EN
  output logic [PERF_W-1:0] perf_bubble_cnt_o,
`endif
  output logic              stall_o
);

  typedef struct packed {
    logic              valid;
    ctrl_t             ctrl;
    logic [XLEN-1:0]   pc;
    logic [XLEN-1:0]   rs1_data;
    logic [XLEN-1:0]   rs2_data;
    logic [XLEN-1:0]   imm;
    logic [REG_AW-1:0] rs1;
    logic [REG_AW-1:0] rs2;
    logic [REG_AW-1:0] rd;
    logic [3:0]        funct;
  } ex_t;

  localparam ex_t EX_BUBBLE = '0;

  ex_t   id_bus;
  ex_t   ex_q;
  ex_t   ex_d;
  ctrl_t id_ctrl;
  logic  hazard;
  logic  bubble_hazard;

  assign id_ctrl = '{
    alu_op:     aluop_e'(ID_ALUop_i),
    alu_src:    ID_ALUsrc_i,
    reg_write:  ID_RegWrite_i,
    mem_read:   ID_MemRead_i,
    mem_write:  ID_MemWrite_i,
    mem_to_reg: ID_MemToReg_i
  };

  assign id_bus = '{
    valid:    ID_valid_i,
    ctrl:     id_ctrl,
    pc:       ID_pc_i,
    rs1_data: ID_rs1_data_i,
    rs2_data: ID_rs2_data_i,
    imm:      ID_imm_i,
    rs1:      ID_rs1_i,
    rs2:      ID_rs2_i,
    rd:       ID_rd_i,
    funct:    ID_funct_i
  };

  load_use_detect #(.REG_AW(REG_AW)) u_load_use_detect (
    .id_valid    (ID_valid_i),
    .id_rs1      (ID_rs1_i),
    .id_rs2      (ID_rs2_i),
    .id_uses_rs2 (uses_rs2(ID_ALUsrc_i, ID_MemWrite_i)),
    .ex_valid    (ex_q.valid),
    .ex_mem_read (ex_q.ctrl.mem_read),
    .ex_rd       (ex_q.rd),
    .hazard      (hazard)
  );

  // A flush already discards the dependent instruction, so it must not stall the front end.
  assign stall_o = ex_stall_i | (hazard & ~flush_i);

  always_comb begin
    ex_d = ex_q;
    if (ex_stall_i) begin
      ex_d = ex_q;
    end else if (flush_i || hazard) begin
      ex_d = EX_BUBBLE;
    end else begin
      ex_d = id_bus;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ex_q <= EX_BUBBLE;
    end else begin
      ex_q <= ex_d;
    end
  end

  assign bubble_hazard = ~ex_stall_i & ~flush_i & hazard;

`ifdef ID_EX_PERF_EN
  logic [PERF_W-1:0] perf_cnt_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      perf_cnt_q <= '0;
    end else if (bubble_hazard && (perf_cnt_q != '1)) begin
      perf_cnt_q <= perf_cnt_q + 1'b1;
    end
  end

  assign perf_bubble_cnt_o = perf_cnt_q;
`else
  logic unused_bubble;
  assign unused_bubble = bubble_hazard;
`endif

  assign EX_valid_o    = ex_q.valid;
  assign EX_ALUop_o    = ex_q.ctrl.alu_op;
  assign EX_ALUsrc_o   = ex_q.ctrl.alu_src;
  assign EX_RegWrite_o = ex_q.ctrl.reg_write;
  assign EX_MemRead_o  = ex_q.ctrl.mem_read;
  assign EX_MemWrite_o = ex_q.ctrl.mem_write;
  assign EX_MemToReg_o = ex_q.ctrl.mem_to_reg;
  assign EX_pc_o       = ex_q.pc;
  assign EX_rs1_data_o = ex_q.rs1_data;
  assign EX_rs2_data_o = ex_q.rs2_data;
  assign EX_imm_o      = ex_q.imm;
  assign EX_rs1_o      = ex_q.rs1;
  assign EX_rs2_o      = ex_q.rs2;
  assign EX_rd_o       = ex_q.rd;
  assign EX_funct_o    = ex_q.funct;

endmodule
